// File: rtl/pool2x2_stream_if.sv
// Stream interface for pool2x2_stream.
// Carries both the input beat stream (in_valid/in_ready/in_data) and the
// pooled output stream (out_valid/out_ready/out_data).
//   slave  : the pooling engine side (consumes in_*, produces out_*)
//   master : the producer/consumer side (drives in_*, accepts out_*)
// Channel c of either data bus sits in bits [c*DW +: DW].
interface pool2x2_stream_if #(
  parameter int DW = 16,
  parameter int CH = 4
) ();
  logic               in_valid;
  logic               in_ready;
  logic [CH*DW-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [CH*DW-1:0]   out_data;

  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
endinterface

// File: rtl/pool2x2_stream.sv
// 2x2 stride-2 pooling engine over a raster-scan feature map.
// One pixel position per beat, CH signed DW-bit channels per beat.
// Ports:
//   clk, nrst        clock, asynchronous active-low reset
//   start            pulse; latches cfg_* when idle
//   cfg_width/height map size (2..MAX_W / 2..MAX_H), smaller => empty frame
//   cfg_mode         0 = max pooling, 1 = average pooling
//   io               stream interface (slave side): input beats, pooled output
//   busy             high while a frame is in progress
//   done             one-cycle pulse at frame end
// Even rows reduce horizontal pairs into a half-width line buffer; odd rows
// reduce their pair and combine it with the stored partial to form a result.

// Per-channel datapath: pair register, line buffer, reduction and result flop.
module pool2x2_lane #(
  parameter int DW  = 16,
  parameter int LBD = 14,
  parameter int LBA = 4
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           mode,
  input  logic           hold_en,
  input  logic           lb_wr,
  input  logic           out_ld,
  input  logic [LBA-1:0] lb_idx,
  input  logic [DW-1:0]  px,
  output logic [DW-1:0]  res_q
);
  logic signed [DW-1:0] pair_q, pair_d;
  logic        [DW-1:0] res_d;
  logic signed [DW:0]   lb_q [LBD];
  logic signed [DW:0]   px_x, pr_x, red, lbv, mx;
  logic signed [DW+1:0] sum4, avg;

  always_comb begin
    pair_d = hold_en ? px : pair_q;
    px_x   = {px[DW-1], px};
    pr_x   = {pair_q[DW-1], pair_q};
    // Pair reduction kept at DW+1 bits so an average-mode sum never overflows.
    red    = mode ? (px_x + pr_x) : ((px_x > pr_x) ? px_x : pr_x);
    lbv    = lb_q[lb_idx];
    mx     = (red > lbv) ? red : lbv;
    sum4   = {red[DW], red} + {lbv[DW], lbv};
    avg    = sum4 >>> 2;  // floor toward -inf
    res_d  = out_ld ? (mode ? DW'(avg) : DW'(mx)) : res_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pair_q <= '0;
      res_q  <= '0;
    end else begin
      pair_q <= pair_d;
      res_q  <= res_d;
    end
  end

  // Line buffer contents need no reset: every entry is written on an even
  // row before the following odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_wr) lb_q[lb_idx] <= red;
  end
endmodule

module pool2x2_stream #(
  parameter int DW    = 16,
  parameter int CH    = 4,
  parameter int MAX_W = 28,
  parameter int MAX_H = 28,
  parameter int CW    = $clog2(MAX_W+1),
  parameter int CHH   = $clog2(MAX_H+1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [CW-1:0]    cfg_width,
  input  logic [CHH-1:0]   cfg_height,
  input  logic             cfg_mode,
  pool2x2_stream_if.slave  io,
  output logic             busy,
  output logic             done
);
  localparam int LBD = MAX_W/2;
  localparam int LBA = (LBD > 1) ? $clog2(LBD) : 1;

  typedef enum logic [2:0] {S_IDLE, S_EVEN_ROW, S_ODD_ROW, S_DRAIN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        col_q, col_d, w_q, w_d;
  logic [CHH-1:0]       row_q, row_d, h_q, h_d;
  logic                 mode_q, mode_d, ov_q, ov_d;
  logic                 in_row, accept, last_col, last_row;
  logic                 hold_en, lb_wr, out_ld;
  logic [LBA-1:0]       lb_idx;
  logic [CH-1:0][DW-1:0] res;

  assign in_row      = (state_q == S_EVEN_ROW) || (state_q == S_ODD_ROW);
  assign busy        = in_row || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);
  // A held result blocks input so the result register is never overwritten
  // while the consumer still owes a handshake.
  assign io.in_ready = busy && in_row && (!ov_q || io.out_ready);
  assign accept      = io.in_valid && io.in_ready;
  assign last_col    = (col_q == w_q - CW'(1));
  assign last_row    = (row_q == h_q - CHH'(1));
  // A trailing even column (odd width) lands in the pair register and is
  // simply never consumed; a trailing even row (odd height) fills the line
  // buffer with nothing ever reading it.
  assign hold_en     = accept && !col_q[0];
  assign lb_wr       = accept && (state_q == S_EVEN_ROW) && col_q[0];
  assign out_ld      = accept && (state_q == S_ODD_ROW) && col_q[0];
  assign lb_idx      = LBA'(col_q >> 1);
  assign io.out_valid = ov_q;
  assign io.out_data  = res;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    w_d     = w_q;
    h_d     = h_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_d    = cfg_width;
          h_d    = cfg_height;
          mode_d = cfg_mode;
          col_d  = '0;
          row_d  = '0;
          state_d = (cfg_width < CW'(2) || cfg_height < CHH'(2)) ? S_DONE : S_EVEN_ROW;
        end
      end
      S_EVEN_ROW, S_ODD_ROW: begin
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + CHH'(1);
            if (last_row) state_d = S_DRAIN;
            else          state_d = row_d[0] ? S_ODD_ROW : S_EVEN_ROW;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DRAIN: if (!ov_q || io.out_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A new result loaded in the same cycle as an output handshake keeps
  // out_valid high with no bubble.
  always_comb begin
    ov_d = ov_q;
    if (out_ld)            ov_d = 1'b1;
    else if (io.out_ready) ov_d = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      w_q     <= '0;
      h_q     <= '0;
      mode_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      w_q     <= w_d;
      h_q     <= h_d;
      mode_q  <= mode_d;
      ov_q    <= ov_d;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    pool2x2_lane #(.DW(DW), .LBD(LBD), .LBA(LBA)) u_lane (
      .clk     (clk),
      .nrst    (nrst),
      .mode    (mode_q),
      .hold_en (hold_en),
      .lb_wr   (lb_wr),
      .out_ld  (out_ld),
      .lb_idx  (lb_idx),
      .px      (io.in_data[c*DW +: DW]),
      .res_q   (res[c])
    );
  end
endmodule

// File: tb/tb_pool2x2_stream.sv
// Directed bench for pool2x2_stream with two channels per beat.
// Channel 1 carries the negation of channel 0, so max mode on channel 1
// yields minus the block minimum and packing errors show up immediately.
module tb_pool2x2_stream;
  localparam int DW = 16, CH = 2, MAX_W = 28, MAX_H = 28;
  localparam int CW = $clog2(MAX_W+1), CHH = $clog2(MAX_H+1), BW = CH*DW;

  logic clk = 1'b0, nrst = 1'b0, start = 1'b0, cfg_mode = 1'b0;
  logic [CW-1:0]  cfg_width = '0;
  logic [CHH-1:0] cfg_height = '0;
  logic busy, done;

  pool2x2_stream_if #(.DW(DW), .CH(CH)) io ();

  pool2x2_stream #(.DW(DW), .CH(CH), .MAX_W(MAX_W), .MAX_H(MAX_H)) dut (
    .clk(clk), .nrst(nrst), .start(start), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .cfg_mode(cfg_mode), .io(io),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [BW-1:0] stim[$], got_q[$], exp_q[$];
  int n_beats, done_lat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk(input int a);
    return {DW'(-a), DW'(a)};
  endfunction

  function automatic logic [BW-1:0] mk2(input int c0, input int c1);
    return {DW'(c1), DW'(c0)};
  endfunction

  task automatic chk_outs(input string tag);
    chk({tag, "_cnt"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
  endtask

  // Runs one frame from stim; optionally stalls the consumer after the first
  // output and/or pulses start mid-frame with a different config.
  task automatic run_frame(input int w, input int h, input bit mode,
                           input int stall, input bit poke);
    int idx = 0, cyc = 0, last_new = -100, stall_left = 0;
    bit stalled = 0, prev_ov = 0, prev_hs = 1, fin = 0, poked = 0, hs_out;
    logic [BW-1:0] held = '0;
    got_q.delete();
    done_lat = -1;
    @(negedge clk);
    cfg_width = CW'(w); cfg_height = CHH'(h); cfg_mode = mode; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 3000) begin
      io.in_valid  = (idx < stim.size());
      io.in_data   = (idx < stim.size()) ? stim[idx] : '0;
      io.out_ready = (stall_left == 0);
      if (poke && idx == 2 && !poked) begin
        start = 1'b1; cfg_width = CW'(4); cfg_height = CHH'(4); cfg_mode = 1'b1; poked = 1;
      end else start = 1'b0;
      #1;
      if (stall > 0 && !stalled && io.out_valid) begin
        stalled = 1; stall_left = stall; held = io.out_data;
        io.out_ready = 1'b0;
        #1;
      end
      if (stall_left > 0) begin
        chk("stall_in_ready", io.in_ready, 0);
        chk("stall_hold", io.out_data, held);
        stall_left--;
      end
      if (io.out_valid && (!prev_ov || prev_hs)) last_new = cyc;
      if (done) begin fin = 1; done_lat = cyc - last_new; end
      if (io.in_valid && io.in_ready) idx++;
      hs_out = io.out_valid && io.out_ready;
      if (hs_out) got_q.push_back(io.out_data);
      prev_ov = io.out_valid; prev_hs = hs_out;
      cyc++;
      @(negedge clk);
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    n_beats = idx;
    chk("frame_finished", fin, 1);
  endtask

  initial begin
    int cnt, first_done, ndone, rdy, bsy;
    io.in_valid = 1'b0; io.in_data = '0; io.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_out_data", io.out_data, 0);
    chk("rst_in_ready", io.in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk); nrst = 1'b1;

    // 4x4 max, pixels 0..15
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(mk(i));
    exp_q.delete();
    exp_q.push_back(mk2(5, 0));  exp_q.push_back(mk2(7, -2));
    exp_q.push_back(mk2(13, -8)); exp_q.push_back(mk2(15, -10));
    run_frame(4, 4, 0, 0, 0);
    chk_outs("max4x4");
    chk("max4x4_beats", n_beats, 16);
    chk("max4x4_done_lat", done_lat, 1);

    // 4x2 average with negative values (floor toward -inf)
    stim.delete();
    stim.push_back(mk(-1)); stim.push_back(mk(-2)); stim.push_back(mk(3)); stim.push_back(mk(4));
    stim.push_back(mk(-3)); stim.push_back(mk(-4)); stim.push_back(mk(5)); stim.push_back(mk(6));
    exp_q.delete();
    exp_q.push_back(mk2(-3, 2)); exp_q.push_back(mk2(4, -5));
    run_frame(4, 2, 1, 0, 0);
    chk_outs("avg4x2");
    chk("avg4x2_beats", n_beats, 8);

    // 5x5 max: trailing column and row carry large values that must vanish
    stim.delete();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        stim.push_back(mk((r == 4 || c == 4) ? 1000 + r*5 + c : r*5 + c));
    exp_q.delete();
    exp_q.push_back(mk2(6, 0));   exp_q.push_back(mk2(8, -2));
    exp_q.push_back(mk2(16, -10)); exp_q.push_back(mk2(18, -12));
    run_frame(5, 5, 0, 0, 0);
    chk_outs("max5x5");
    chk("max5x5_beats", n_beats, 25);

    // 4x4 max with a 10-cycle consumer stall after the first output
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(mk(i));
    exp_q.delete();
    exp_q.push_back(mk2(5, 0));  exp_q.push_back(mk2(7, -2));
    exp_q.push_back(mk2(13, -8)); exp_q.push_back(mk2(15, -10));
    run_frame(4, 4, 0, 10, 0);
    chk_outs("stall");
    chk("stall_beats", n_beats, 16);

    // Reset in the middle of row 1 of a 28x28 frame
    @(negedge clk);
    cfg_width = CW'(28); cfg_height = CHH'(28); cfg_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cnt = 0;
    for (int k = 0; k < 38; k++) begin
      io.in_valid = 1'b1; io.in_data = mk(k + 1);
      #1;
      if (io.in_ready) cnt++;
      @(negedge clk);
    end
    chk("mid_beats", cnt, 38);
    chk("mid_pre_rst_ov", io.out_valid, 1);
    nrst = 1'b0; io.in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", io.out_valid, 0);
    chk("mid_rst_out_data", io.out_data, 0);
    chk("mid_rst_in_ready", io.in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    stim.delete();
    stim.push_back(mk(3)); stim.push_back(mk(-7)); stim.push_back(mk(9)); stim.push_back(mk(2));
    exp_q.delete();
    exp_q.push_back(mk2(9, 7));
    run_frame(2, 2, 0, 0, 0);
    chk_outs("post_rst");

    // Width 1: empty frame, done quickly, no input consumed
    @(negedge clk);
    cfg_width = CW'(1); cfg_height = CHH'(4); cfg_mode = 1'b0; start = 1'b1;
    #1;
    rdy = io.in_ready;
    @(negedge clk);
    start = 1'b0; first_done = -1; ndone = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (done) begin ndone++; if (first_done < 0) first_done = i + 1; end
      rdy |= io.in_ready;
      @(negedge clk);
    end
    chk("w1_done_within2", (first_done >= 1 && first_done <= 2), 1);
    chk("w1_done_pulses", ndone, 1);
    chk("w1_no_in_ready", rdy, 0);

    // start while busy is ignored
    stim.delete();
    stim.push_back(mk(-5)); stim.push_back(mk(-2)); stim.push_back(mk(-9)); stim.push_back(mk(-4));
    exp_q.delete();
    exp_q.push_back(mk2(-2, 9));
    run_frame(2, 2, 0, 0, 1);
    chk_outs("poke");
    chk("poke_beats", n_beats, 4);
    bsy = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (busy) bsy++;
    end
    chk("poke_idle_after", bsy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
